// File: rtl/prio_encoder_hs.sv
`default_nettype none
// ============================================================================
//  Module      : prio_encoder_hs
//  Description : Registered priority encoder with sticky pending requests,
//                per-line masking, fixed or round-robin selection and a
//                valid/ready output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module prio_encoder_hs #(
    parameter int WIDTH = 8,
    parameter int EDGE  = 1,
    parameter int RR    = 0,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] mask,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic             none,
    output logic [WIDTH-1:0] pend
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_req_q;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_elig;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nx;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_sel;
    logic             w_hs;
    logic             w_any;

    assign w_hs   = (r_state == S_PRESENT) && out_ready;
    assign w_set  = (EDGE != 0) ? (req & ~r_req_q) : req;
    assign w_clr  = w_hs ? (c_one << r_idx) : '0;
    assign w_elig = r_pend & ~mask & ~w_clr;
    assign w_any  = |w_elig;
    assign w_base = (RR != 0) ? r_rr_ptr : '0;

    // Walk from lowest to highest priority so the last hit is the winner.
    // Rank 0 (highest) is index base-1, wrapping down to base itself.
    always_comb begin
        int j;
        j     = 0;
        w_sel = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            j = (int'(w_base) + 2 * WIDTH - 1 - i) % WIDTH;
            if (w_elig[IDX_W'(j)]) begin
                w_sel = IDX_W'(j);
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nx = S_PRESENT;
                    w_idx_nx   = w_sel;
                end
            end
            S_PRESENT: begin
                if (w_hs) begin
                    if (w_any) begin
                        w_idx_nx = w_sel;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_req_q  <= '0;
            r_pend   <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_req_q <= req;
            // Set is OR'd after the clear so a same-edge re-request survives.
            r_pend  <= (r_pend & ~w_clr) | w_set;
            if (w_hs && (RR != 0)) begin
                r_rr_ptr <= r_idx;
            end
        end
    end

    assign out_valid = (r_state == S_PRESENT);
    assign out_idx   = r_idx;
    assign pend      = r_pend;
    assign none      = ~out_valid & ~|(r_pend & ~mask);

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_hs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_encoder_hs
//  Description : Self-checking bench for prio_encoder_hs (fixed, round-robin,
//                level-mode and 5-line variants).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prio_encoder_hs;

    logic clk;
    logic rst;

    logic [7:0] fp_req, fp_mask, fp_pend;
    logic       fp_rdy, fp_v, fp_none;
    logic [2:0] fp_idx;

    logic [7:0] rr_req, rr_mask, rr_pend;
    logic       rr_rdy, rr_v, rr_none;
    logic [2:0] rr_idx;

    logic [7:0] lv_req, lv_mask, lv_pend;
    logic       lv_rdy, lv_v, lv_none;
    logic [2:0] lv_idx;

    logic [4:0] w5_req, w5_mask, w5_pend;
    logic       w5_rdy, w5_v, w5_none;
    logic [2:0] w5_idx;

    int n_cmp;
    int n_err;
    int exp_q[$];

    prio_encoder_hs #(.WIDTH(8), .EDGE(1), .RR(0)) u_fp (
        .clk(clk), .rst(rst), .req(fp_req), .mask(fp_mask), .out_valid(fp_v),
        .out_idx(fp_idx), .out_ready(fp_rdy), .none(fp_none), .pend(fp_pend)
    );
    prio_encoder_hs #(.WIDTH(8), .EDGE(1), .RR(1)) u_rr (
        .clk(clk), .rst(rst), .req(rr_req), .mask(rr_mask), .out_valid(rr_v),
        .out_idx(rr_idx), .out_ready(rr_rdy), .none(rr_none), .pend(rr_pend)
    );
    prio_encoder_hs #(.WIDTH(8), .EDGE(0), .RR(1)) u_lv (
        .clk(clk), .rst(rst), .req(lv_req), .mask(lv_mask), .out_valid(lv_v),
        .out_idx(lv_idx), .out_ready(lv_rdy), .none(lv_none), .pend(lv_pend)
    );
    prio_encoder_hs #(.WIDTH(5), .EDGE(1), .RR(0)) u_w5 (
        .clk(clk), .rst(rst), .req(w5_req), .mask(w5_mask), .out_valid(w5_v),
        .out_idx(w5_idx), .out_ready(w5_rdy), .none(w5_none), .pend(w5_pend)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #2;
        n_cmp++; if (fp_v !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", fp_v); end
        n_cmp++; if (fp_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d expected 0", fp_idx); end
        n_cmp++; if (fp_pend !== 8'h00) begin n_err++; $display("FAIL reset_pend: got %h expected 00", fp_pend); end
        n_cmp++; if (fp_none !== 1'b1) begin n_err++; $display("FAIL reset_none: got %b expected 1", fp_none); end
        n_cmp++; if (rr_v !== 1'b0) begin n_err++; $display("FAIL reset_rr_valid: got %b expected 0", rr_v); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (fp_none !== 1'b1) begin n_err++; $display("FAIL post_reset_none: got %b expected 1", fp_none); end
    endtask

    task automatic test_fixed_hold();
        int e;
        @(negedge clk);
        fp_req = 8'h81; fp_rdy = 1'b0;
        @(negedge clk);
        fp_req = 8'h00;
        n_cmp++; if (fp_pend !== 8'h81) begin n_err++; $display("FAIL fixed_pend: got %h expected 81", fp_pend); end
        n_cmp++; if (fp_v !== 1'b0) begin n_err++; $display("FAIL fixed_latency: got %b expected 0", fp_v); end
        @(negedge clk);
        n_cmp++; if (fp_v !== 1'b1 || fp_idx !== 3'd7) begin n_err++; $display("FAIL fixed_first: got v=%b idx=%0d expected v=1 idx=7", fp_v, fp_idx); end
        repeat (2) begin
            @(negedge clk);
            n_cmp++; if (fp_v !== 1'b1 || fp_idx !== 3'd7) begin n_err++; $display("FAIL fixed_hold: got v=%b idx=%0d expected v=1 idx=7", fp_v, fp_idx); end
        end
        exp_q.push_back(7); exp_q.push_back(0);
        fp_rdy = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (fp_v) begin
                e = exp_q.pop_front();
                n_cmp++; if (int'(fp_idx) !== e) begin n_err++; $display("FAIL fixed_grant: got %0d expected %0d", fp_idx, e); end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fixed_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        fp_rdy = 1'b0;
        n_cmp++; if (fp_v !== 1'b0 || fp_none !== 1'b1) begin n_err++; $display("FAIL fixed_idle: got v=%b none=%b expected v=0 none=1", fp_v, fp_none); end
    endtask

    task automatic test_rr();
        int e;
        @(negedge clk);
        rr_req = 8'hFF; rr_rdy = 1'b1;
        for (int k = 7; k >= 0; k--) exp_q.push_back(k);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            if (rr_v) begin
                e = exp_q.pop_front();
                n_cmp++; if (int'(rr_idx) !== e) begin n_err++; $display("FAIL rr_grant: got %0d expected %0d", rr_idx, e); end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        repeat (2) @(negedge clk);
        n_cmp++; if (rr_v !== 1'b0 || rr_pend !== 8'h00) begin n_err++; $display("FAIL rr_no_repeat: got v=%b pend=%h expected v=0 pend=00", rr_v, rr_pend); end
        rr_req = 8'h00;
        @(negedge clk);
        rr_req = 8'hFF;
        for (int k = 7; k >= 0; k--) exp_q.push_back(k);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            if (rr_v) begin
                e = exp_q.pop_front();
                n_cmp++; if (int'(rr_idx) !== e) begin n_err++; $display("FAIL rr_regrant: got %0d expected %0d", rr_idx, e); end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_regrant_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        rr_req = 8'h00; rr_rdy = 1'b0;
    endtask

    task automatic test_same_edge();
        int e;
        @(negedge clk);
        rr_req = 8'h0E;
        @(negedge clk);
        rr_req = 8'h00;
        @(negedge clk);
        exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(3);
        e = exp_q.pop_front();
        n_cmp++; if (rr_v !== 1'b1 || int'(rr_idx) !== e) begin n_err++; $display("FAIL same_first: got v=%b idx=%0d expected v=1 idx=%0d", rr_v, rr_idx, e); end
        rr_rdy = 1'b1; rr_req = 8'h08;
        @(negedge clk);
        rr_req = 8'h00;
        n_cmp++; if (rr_pend[3] !== 1'b1) begin n_err++; $display("FAIL same_edge_pend: got %b expected 1", rr_pend[3]); end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (rr_v) begin
                e = exp_q.pop_front();
                n_cmp++; if (int'(rr_idx) !== e) begin n_err++; $display("FAIL same_edge_grant: got %0d expected %0d", rr_idx, e); end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL same_edge_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        rr_rdy = 1'b0;
        n_cmp++; if (rr_v !== 1'b0) begin n_err++; $display("FAIL same_edge_idle: got %b expected 0", rr_v); end
    endtask

    task automatic test_level();
        int e;
        @(negedge clk);
        lv_req = 8'hFF; lv_rdy = 1'b1;
        for (int k = 7; k >= 0; k--) exp_q.push_back(k);
        exp_q.push_back(7); exp_q.push_back(6); exp_q.push_back(5);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            if (lv_v) begin
                e = exp_q.pop_front();
                n_cmp++; if (int'(lv_idx) !== e) begin n_err++; $display("FAIL level_grant: got %0d expected %0d", lv_idx, e); end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL level_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        lv_req = 8'h00;
    endtask

    task automatic test_mask();
        int e;
        @(negedge clk);
        fp_mask = 8'h10; fp_req = 8'h10; fp_rdy = 1'b0;
        @(negedge clk);
        fp_req = 8'h00;
        n_cmp++; if (fp_pend !== 8'h10) begin n_err++; $display("FAIL mask_pend: got %h expected 10", fp_pend); end
        @(negedge clk);
        n_cmp++; if (fp_v !== 1'b0 || fp_none !== 1'b1) begin n_err++; $display("FAIL mask_blocked: got v=%b none=%b expected v=0 none=1", fp_v, fp_none); end
        @(negedge clk);
        n_cmp++; if (fp_v !== 1'b0 || fp_pend !== 8'h10) begin n_err++; $display("FAIL mask_hold: got v=%b pend=%h expected v=0 pend=10", fp_v, fp_pend); end
        fp_mask = 8'h00;
        @(negedge clk);
        n_cmp++; if (fp_v !== 1'b1 || fp_idx !== 3'd4) begin n_err++; $display("FAIL mask_release: got v=%b idx=%0d expected v=1 idx=4", fp_v, fp_idx); end
        exp_q.push_back(4);
        fp_rdy = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (fp_v) begin
                e = exp_q.pop_front();
                n_cmp++; if (int'(fp_idx) !== e) begin n_err++; $display("FAIL mask_grant: got %0d expected %0d", fp_idx, e); end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mask_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        fp_rdy = 1'b0;
    endtask

    task automatic test_hold_stability();
        int e;
        @(negedge clk);
        fp_req = 8'h04; fp_rdy = 1'b0;
        @(negedge clk);
        fp_req = 8'h00;
        @(negedge clk);
        n_cmp++; if (fp_v !== 1'b1 || fp_idx !== 3'd2) begin n_err++; $display("FAIL hold_first: got v=%b idx=%0d expected v=1 idx=2", fp_v, fp_idx); end
        fp_req = 8'h40; fp_mask = 8'h04;
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (fp_v !== 1'b1 || fp_idx !== 3'd2) begin n_err++; $display("FAIL hold_stable: got v=%b idx=%0d expected v=1 idx=2", fp_v, fp_idx); end
        end
        exp_q.push_back(2); exp_q.push_back(6);
        fp_rdy = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (fp_v) begin
                e = exp_q.pop_front();
                n_cmp++; if (int'(fp_idx) !== e) begin n_err++; $display("FAIL hold_grant: got %0d expected %0d", fp_idx, e); end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL hold_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        fp_rdy = 1'b0; fp_req = 8'h00; fp_mask = 8'h00;
        n_cmp++; if (fp_v !== 1'b0) begin n_err++; $display("FAIL hold_idle: got %b expected 0", fp_v); end
    endtask

    task automatic test_async_reset();
        int e;
        @(negedge clk);
        fp_req = 8'h0A; fp_rdy = 1'b0;
        @(negedge clk);
        fp_req = 8'h02;
        @(negedge clk);
        n_cmp++; if (fp_v !== 1'b1 || fp_idx !== 3'd3) begin n_err++; $display("FAIL areset_pre: got v=%b idx=%0d expected v=1 idx=3", fp_v, fp_idx); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (fp_v !== 1'b0 || fp_pend !== 8'h00 || fp_idx !== 3'd0) begin n_err++; $display("FAIL areset_immediate: got v=%b pend=%h idx=%0d expected v=0 pend=00 idx=0", fp_v, fp_pend, fp_idx); end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (fp_none !== 1'b1) begin n_err++; $display("FAIL areset_none: got %b expected 1", fp_none); end
        @(negedge clk);
        n_cmp++; if (fp_pend !== 8'h02 || fp_v !== 1'b0) begin n_err++; $display("FAIL areset_rearm: got pend=%h v=%b expected pend=02 v=0", fp_pend, fp_v); end
        exp_q.push_back(1);
        fp_rdy = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (fp_v) begin
                e = exp_q.pop_front();
                n_cmp++; if (int'(fp_idx) !== e) begin n_err++; $display("FAIL areset_grant: got %0d expected %0d", fp_idx, e); end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL areset_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        fp_rdy = 1'b0; fp_req = 8'h00;
    endtask

    task automatic test_width5();
        int e;
        @(negedge clk);
        w5_req = 5'h1F; w5_rdy = 1'b1;
        for (int k = 4; k >= 0; k--) exp_q.push_back(k);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (w5_v) begin
                e = exp_q.pop_front();
                n_cmp++; if (int'(w5_idx) !== e) begin n_err++; $display("FAIL w5_grant: got %0d expected %0d", w5_idx, e); end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL w5_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        n_cmp++; if (w5_v !== 1'b0 || w5_none !== 1'b1) begin n_err++; $display("FAIL w5_idle: got v=%b none=%b expected v=0 none=1", w5_v, w5_none); end
        w5_req = 5'h00; w5_rdy = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        clk = 1'b0; rst = 1'b1;
        fp_req = '0; fp_mask = '0; fp_rdy = 1'b0;
        rr_req = '0; rr_mask = '0; rr_rdy = 1'b0;
        lv_req = '0; lv_mask = '0; lv_rdy = 1'b0;
        w5_req = '0; w5_mask = '0; w5_rdy = 1'b0;
        test_reset();
        test_fixed_hold();
        test_rr();
        test_same_edge();
        test_level();
        test_mask();
        test_hold_stability();
        test_async_reset();
        test_width5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
